uart_tx: RTL and testbench

UART transmitter: serialises one byte per request into an 8N1 frame (start bit, 8 data bits LSB first, one stop bit) on a single line. It carries its own bit-period divider, so no external baud tick is needed. It sits on the transmit side of the comm block, opposite the receive path, and feeds results from the sparse-matrix core back to the host at the same baud rate.

---
 rtl/uart_tx.sv | 56 +++++
 tb/tb_uart_tx.sv | 108 ++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a built-in bit-period divider.
module uart_tx #(
  parameter int BAUDRATE = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       start,
  output logic       ready,
  output logic       tx
);
  localparam int DW = $clog2(BAUDRATE);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state;
  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic [DW-1:0] divcnt;
  logic          bitend;
  assign bitend = divcnt == DW'(BAUDRATE - 1);
  assign ready  = state == IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tx     <= 1'b1;
      shreg  <= '0;
      bitcnt <= '0;
      divcnt <= '0;
    end else begin
      divcnt <= (state == IDLE || bitend) ? '0 : divcnt + 1'b1;
      case (state)
        IDLE: if (start) begin
          shreg <= data;
          tx    <= 1'b0;
          state <= START;
        end
        START: if (bitend) begin
          tx     <= shreg[0];
          shreg  <= shreg >> 1;
          bitcnt <= '0;
          state  <= DATA;
        end
        DATA: if (bitend) begin
          if (bitcnt == 3'd7) begin
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            tx     <= shreg[0];
            shreg  <= shreg >> 1;
            bitcnt <= bitcnt + 1'b1;
          end
        end
        default: if (bitend) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx framing, back-to-back, busy, reset and default divisor.
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_a = '0, data_b = '0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       ready_a, tx_a, ready_b, tx_b;
  int         errs = 0, checks = 0;
  uart_tx #(.BAUDRATE(4)) u_a (.clk(clk), .rst(rst), .data(data_a), .start(start_a), .ready(ready_a), .tx(tx_a));
  uart_tx u_b (.clk(clk), .rst(rst), .data(data_b), .start(start_b), .ready(ready_b), .tx(tx_b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] d);
    data_a  = d;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask
  // Called in the cycle after the accept edge; checks n cycles of the frame.
  task automatic frame(input string tag, input logic [7:0] d, input int n, input bit poke);
    logic [9:0] bits;
    bits = {1'b1, d, 1'b0};
    for (int j = 0; j < n; j++) begin
      if (poke && j == 12) begin
        start_a = 1'b1;
        data_a  = 8'hFF;
      end
      if (poke && j == 13) start_a = 1'b0;
      chk($sformatf("%s tx[%0d]", tag, j), tx_a, bits[j / 4]);
      chk($sformatf("%s ready[%0d]", tag, j), ready_a, 1'b0);
      @(negedge clk);
    end
    if (n == 40) begin
      chk({tag, " ready_end"}, ready_a, 1'b1);
      chk({tag, " tx_end"}, tx_a, 1'b1);
    end
  endtask
  initial begin
    int n0, total;
    start_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst tx", tx_a, 1'b1);
      chk("rst ready", ready_a, 1'b1);
      chk("rst tx_b", tx_b, 1'b1);
      chk("rst ready_b", ready_b, 1'b1);
    end
    rst = 1'b0;
    start_a = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post rst tx", tx_a, 1'b1);
      chk("post rst ready", ready_a, 1'b1);
    end
    send(8'hA5);
    frame("a5", 8'hA5, 40, 1'b0);
    data_a  = 8'h00;
    start_a = 1'b1;
    @(negedge clk);
    data_a = 8'hFF;
    frame("b2b0", 8'h00, 40, 1'b0);
    @(negedge clk);
    start_a = 1'b0;
    frame("b2b1", 8'hFF, 40, 1'b0);
    send(8'h3C);
    frame("busy", 8'h3C, 40, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no extra tx", tx_a, 1'b1);
      chk("no extra ready", ready_a, 1'b1);
    end
    send(8'h55);
    frame("abort", 8'h55, 18, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst tx", tx_a, 1'b1);
    chk("midrst ready", ready_a, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("midrst idle tx", tx_a, 1'b1);
    end
    send(8'h96);
    frame("after rst", 8'h96, 40, 1'b0);
    data_b  = 8'h41;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n0 = 0;
    total = 0;
    while (!ready_b && total < 5000) begin
      if (tx_b == 1'b0 && total == n0) n0++;
      total++;
      @(negedge clk);
    end
    chk("def start bit", n0, 434);
    chk("def frame", total, 4340);
    chk("def tx idle", tx_b, 1'b1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
